// File: rtl/game2048_pkg.sv
// Shared types, defaults and board helpers for the 2048 datapath
// (slide blocks, tile spawner, display).
package game2048_pkg;

    typedef logic [3:0]       cell_t;
    typedef logic [15:0][3:0] matrix_t;

    localparam int unsigned WIN_EXP_DEFAULT   = 11;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCheck,
        StDone
    } spawn_state_e;

    function automatic logic has_cell(matrix_t m, cell_t v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (m[i] == v) r = 1'b1;
        end
        return r;
    endfunction

    // True when some pair of orthogonal neighbours could still merge.
    function automatic logic has_merge(matrix_t m);
        logic r;
        r = 1'b0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 3; col++) begin
                if (m[row*4+col] == m[row*4+col+1]) r = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (m[i] == m[i+4]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// Request/result bundle between the slide stage, the tile spawner and the
// board state register.
interface tile_spawner_if;
    import game2048_pkg::*;

    logic    start;
    logic    new_game;
    matrix_t prev_matrix;
    matrix_t slid_matrix;
    matrix_t matrix_out;
    logic    busy;
    logic    done;
    logic    moved;
    logic    game_won;
    logic    game_over;

    modport master (
        output start, new_game, prev_matrix, slid_matrix,
        input  matrix_out, busy, done, moved, game_won, game_over
    );

    modport slave (
        input  start, new_game, prev_matrix, slid_matrix,
        output matrix_out, busy, done, moved, game_won, game_over
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1; never reaches zero
// from a nonzero seed.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]};
        if (state_q[0]) state_d = state_d ^ 16'hB400;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/tile_spawner.sv
// Inserts a pseudo-random tile after a board-changing slide, evaluates win and
// game-over, and builds the two-tile starting board. SPAWN_FOUR_EN enables 4-tiles.
module tile_spawner
    import game2048_pkg::*;
#(
    parameter int unsigned WIN_EXP   = WIN_EXP_DEFAULT,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    tile_spawner_if.slave bus
);

    localparam cell_t WinCell = cell_t'(WIN_EXP);

    logic [15:0]  lfsr;
    cell_t        spawn_val;

    spawn_state_e state_q, state_d;
    matrix_t      work_q, work_d;
    matrix_t      matrix_q, matrix_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         moved_q, moved_d;
    logic         won_q, won_d;
    logic         over_q, over_d;
    logic [1:0]   spawns_q, spawns_d;
    logic [3:0]   scan_idx_q, scan_idx_d;
    logic [3:0]   scan_cnt_q, scan_cnt_d;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr)
    );

`ifdef SPAWN_FOUR_EN
    assign spawn_val = (lfsr[6:4] == 3'b000) ? cell_t'(2) : cell_t'(1);
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[15:7];
`else
    assign spawn_val = cell_t'(1);
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[15:4];
`endif

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        matrix_d   = matrix_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        moved_d    = moved_q;
        won_d      = won_q;
        over_d     = over_q;
        spawns_d   = spawns_q;
        scan_idx_d = scan_idx_q;
        scan_cnt_d = scan_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.new_game) begin
                    work_d     = '0;
                    moved_d    = 1'b1;
                    spawns_d   = 2'd2;
                    scan_idx_d = lfsr[3:0];
                    scan_cnt_d = 4'd0;
                    busy_d     = 1'b1;
                    state_d    = StScan;
                end else if (bus.start) begin
                    work_d  = bus.slid_matrix;
                    moved_d = (bus.slid_matrix != bus.prev_matrix);
                    busy_d  = 1'b1;
                    if (bus.slid_matrix != bus.prev_matrix) begin
                        spawns_d   = 2'd1;
                        scan_idx_d = lfsr[3:0];
                        scan_cnt_d = 4'd0;
                        state_d    = StScan;
                    end else begin
                        state_d = StCheck;
                    end
                end
            end
            StScan: begin
                if (work_q[scan_idx_q] == '0) begin
                    work_d[scan_idx_q] = spawn_val;
                    spawns_d           = spawns_q - 2'd1;
                    if (spawns_q == 2'd1) begin
                        state_d = StCheck;
                    end else begin
                        scan_idx_d = lfsr[3:0];
                        scan_cnt_d = 4'd0;
                    end
                end else if (scan_cnt_q == 4'd15) begin
                    // Every cell visited and occupied: nothing to spawn.
                    state_d = StCheck;
                end else begin
                    scan_idx_d = scan_idx_q + 4'd1;
                    scan_cnt_d = scan_cnt_q + 4'd1;
                end
            end
            StCheck: begin
                won_d    = has_cell(work_q, WinCell);
                over_d   = !has_cell(work_q, cell_t'(0)) && !has_merge(work_q);
                matrix_d = work_q;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            work_q     <= '0;
            matrix_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            moved_q    <= 1'b0;
            won_q      <= 1'b0;
            over_q     <= 1'b0;
            spawns_q   <= 2'd0;
            scan_idx_q <= 4'd0;
            scan_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            matrix_q   <= matrix_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            moved_q    <= moved_d;
            won_q      <= won_d;
            over_q     <= over_d;
            spawns_q   <= spawns_d;
            scan_idx_q <= scan_idx_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    assign bus.matrix_out = matrix_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.moved      = moved_q;
    assign bus.game_won   = won_q;
    assign bus.game_over  = over_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Scoreboard bench for tile_spawner: stimulus queues expected results, a monitor
// checks them whenever done pulses.
module tb_tile_spawner;
    import game2048_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_spawner_if bus_if ();

    tile_spawner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        int      id;
        matrix_t m;       // exact board, or the cells that must survive unchanged
        logic    exact;
        int      spawns;  // new tiles expected when not exact
        logic    moved;
        logic    won;
        logic    over;
        int      lat;     // >= 0: exact done cycle; < 0: upper bound -lat
        int      t0;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_mat(input string name, input matrix_t act, input matrix_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int id, input matrix_t m, input logic exact,
                                input int spawns, input logic moved, input logic won,
                                input logic over, input int lat);
        exp_t e;
        e.id = id; e.m = m; e.exact = exact; e.spawns = spawns;
        e.moved = moved; e.won = won; e.over = over; e.lat = lat; e.t0 = 0;
        return e;
    endfunction

    function automatic matrix_t checker_board();
        matrix_t m;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                m[r*4+c] = (((r + c) % 2) != 0) ? 4'd2 : 4'd1;
            end
        end
        return m;
    endfunction

    // Monitor: compare every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   nz;
        int   kept;
        int   lat;
        if (rst_n && bus_if.done) begin
            if (sb.size() == 0) begin
                check_int("unexpected_done", 1, 0);
            end else begin
                e   = sb.pop_front();
                lat = cyc - e.t0;
                if (e.exact) begin
                    check_mat($sformatf("item%0d.matrix", e.id), bus_if.matrix_out, e.m);
                end else begin
                    nz   = 0;
                    kept = 1;
                    for (int i = 0; i < 16; i++) begin
                        if (e.m[i] != 4'd0) begin
                            if (bus_if.matrix_out[i] != e.m[i]) kept = 0;
                        end else if (bus_if.matrix_out[i] != 4'd0) begin
                            nz++;
                            if (bus_if.matrix_out[i] != 4'd1) kept = 0;
                        end
                    end
                    check_int($sformatf("item%0d.kept", e.id), kept, 1);
                    check_int($sformatf("item%0d.spawns", e.id), nz, e.spawns);
                end
                check_int($sformatf("item%0d.moved", e.id), int'(bus_if.moved), int'(e.moved));
                check_int($sformatf("item%0d.won", e.id), int'(bus_if.game_won), int'(e.won));
                check_int($sformatf("item%0d.over", e.id), int'(bus_if.game_over), int'(e.over));
                if (e.lat >= 0) check_int($sformatf("item%0d.latency", e.id), lat, e.lat);
                else check_int($sformatf("item%0d.latency_le_%0d", e.id, -e.lat),
                               int'(lat <= -e.lat), 1);
            end
        end
    end

    // Called at a negedge; the request is sampled at the following posedge.
    task automatic issue(input logic ng, input matrix_t prev, input matrix_t slid,
                         input exp_t e);
        bus_if.prev_matrix = prev;
        bus_if.slid_matrix = slid;
        bus_if.new_game    = ng;
        bus_if.start       = !ng;
        e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.new_game = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check_int("done_timeout", 1, 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_mat({tag, ".matrix_out"}, bus_if.matrix_out, '0);
        check_int({tag, ".busy"}, int'(bus_if.busy), 0);
        check_int({tag, ".done"}, int'(bus_if.done), 0);
        check_int({tag, ".moved"}, int'(bus_if.moved), 0);
        check_int({tag, ".won"}, int'(bus_if.game_won), 0);
        check_int({tag, ".over"}, int'(bus_if.game_over), 0);
        check_int({tag, ".lfsr"}, int'(dut.u_lfsr.state_o), int'(16'hACE1));
    endtask

    initial begin
        matrix_t z, one0, one4, two01, cb, cb_hole, stray, win;
        int      found;

        z     = '0;
        one0  = '0; one0[0] = 4'd1;
        one4  = '0; one4[4] = 4'd1;
        two01 = one0; two01[1] = 4'd1;
        cb    = checker_board();
        cb_hole = cb; cb_hole[15] = 4'd0;
        stray = '0; stray[7] = 4'd3;
        win   = '0; win[0] = 4'd11;

        bus_if.start = 1'b0;
        bus_if.new_game = 1'b0;
        bus_if.prev_matrix = '0;
        bus_if.slid_matrix = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);

        issue(1'b1, z, z, mk(1, z, 1'b0, 2, 1'b1, 1'b0, 1'b0, -35));
        drain();

        issue(1'b0, one0, one0, mk(2, one0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2));
        drain();

        // Align the start with a cycle whose LFSR low nibble targets cell 0.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (dut.u_lfsr.state_o[3:0] == 4'd0) found = 1;
            else @(negedge clk);
        end
        check_int("lfsr_target0_found", found, 1);
        issue(1'b0, one4, one0, mk(3, two01, 1'b1, 0, 1'b1, 1'b0, 1'b0, 4));
        drain();

        // Full board: 16-cell scan; a start pulsed mid-scan must be ignored.
        issue(1'b0, z, cb, mk(4, cb, 1'b1, 0, 1'b1, 1'b0, 1'b1, 18));
        repeat (2) @(negedge clk);
        check_int("scan.busy", int'(bus_if.busy), 1);
        bus_if.slid_matrix = stray;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        drain();

        issue(1'b0, z, cb_hole, mk(5, cb, 1'b1, 0, 1'b1, 1'b0, 1'b1, -18));
        drain();

        issue(1'b0, z, win, mk(6, win, 1'b0, 1, 1'b1, 1'b1, 1'b0, -18));
        drain();

        // Reset asserted while scanning a full board.
        issue(1'b0, z, cb, mk(7, cb, 1'b1, 0, 1'b1, 1'b0, 1'b1, 18));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_scan");
        check_int("rst_scan.state", int'(dut.state_q), int'(StIdle));
        check_int("rst_scan.spawns_left", int'(dut.spawns_q), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_int("rst_release.lfsr", int'(dut.u_lfsr.state_o), int'(16'hACE1));
        @(negedge clk);

        issue(1'b0, one0, one0, mk(8, one0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
